// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave that turns single read/write requests into HD44780 bus cycles
// with programmable setup, enable-high, hold and inter-cycle gap timing.
module lcd_bus_sequencer #(
   parameter int T_SETUP = 2,
   parameter int T_EHIGH = 12,
   parameter int T_HOLD  = 2,
   parameter int T_GAP   = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] address,
   input  logic       read,
   input  logic       write,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic       waitrequest,
   output logic       LCD_E,
   output logic       LCD_RS,
   output logic       LCD_RW,
   inout  wire  [7:0] LCD_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_EHIGH,
      S_HOLD,
      S_DONE,
      S_GAP
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rs_q, rs_d;
   logic       rw_lat_q, rw_lat_d;
   logic       wr_lat_q, wr_lat_d;
   logic       e_q, e_d;
   logic       rw_q, rw_d;
   logic       drive_q, drive_d;
   logic       in_cycle_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rs_d     = rs_q;
      rw_lat_d = rw_lat_q;
      wr_lat_d = wr_lat_q;

      case (state_q)
         S_IDLE: begin
            if (read || write) begin
               state_d  = S_SETUP;
               cnt_d    = 8'(T_SETUP - 1);
               rs_d     = address[1];
               // A write (alone or together with a read) always runs as RW=0.
               rw_lat_d = write ? 1'b0 : address[0];
               wr_lat_d = write;
               wdata_d  = writedata;
            end
         end
         S_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_EHIGH;
               cnt_d   = 8'(T_EHIGH - 1);
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_EHIGH: begin
            if (cnt_q == 8'd0) begin
               state_d = S_HOLD;
               cnt_d   = 8'(T_HOLD - 1);
               if (!wr_lat_q) begin
                  rdata_d = LCD_data;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d = S_DONE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DONE: begin
            if (T_GAP == 0) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end else begin
               state_d = S_GAP;
               cnt_d   = 8'(T_GAP - 1);
            end
         end
         S_GAP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      // Bus pins are registered from the next state so they change on the state edge.
      in_cycle_d = (state_d == S_SETUP) || (state_d == S_EHIGH) ||
                   (state_d == S_HOLD)  || (state_d == S_DONE);
      e_d        = (state_d == S_EHIGH);
      rw_d       = in_cycle_d ? rw_lat_d : 1'b1;
      drive_d    = in_cycle_d && wr_lat_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         rdata_q <= 8'h00;
         rs_q    <= 1'b0;
         e_q     <= 1'b0;
         rw_q    <= 1'b1;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         rs_q    <= rs_d;
         e_q     <= e_d;
         rw_q    <= rw_d;
         drive_q <= drive_d;
      end
      wdata_q  <= wdata_d;
      rw_lat_q <= rw_lat_d;
      wr_lat_q <= wr_lat_d;
   end

   assign waitrequest = (read || write) && (state_q != S_DONE);
   assign readdata    = rdata_q;
   assign LCD_E       = e_q;
   assign LCD_RS      = rs_q;
   assign LCD_RW      = rw_q;
   assign LCD_data    = drive_q ? wdata_q : 8'bz;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Bench for lcd_bus_sequencer: vector table with a scoreboard queue, plus cycle
// traces for back-to-back, mid-cycle reset and minimum-timing corner cases.
module tb_lcd_bus_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [1:0] address;
   logic       read, write;
   logic [7:0] writedata, readdata;
   logic       waitrequest, lcd_e, lcd_rs, lcd_rw;
   wire  [7:0] lcd_bus;
   logic [7:0] lcd_val;

   logic [1:0] address_f;
   logic       read_f, write_f;
   logic [7:0] writedata_f, readdata_f;
   logic       waitrequest_f, lcd_e_f, lcd_rs_f, lcd_rw_f;
   wire  [7:0] lcd_bus_f;

   // Undriven bus reads back as 8'hFF so a released bus is observable.
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (lcd_bus[i]);
      pullup (lcd_bus_f[i]);
   end

   // LCD model: drives its response while E is high on a read cycle.
   assign lcd_bus = (lcd_e && lcd_rw) ? lcd_val : 8'bz;

   lcd_bus_sequencer dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
      .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_data(lcd_bus)
   );

   lcd_bus_sequencer #(.T_SETUP(1), .T_EHIGH(1), .T_HOLD(1), .T_GAP(0)) dut_fast (
      .clk(clk), .reset(reset), .address(address_f), .read(read_f), .write(write_f),
      .writedata(writedata_f), .readdata(readdata_f), .waitrequest(waitrequest_f),
      .LCD_E(lcd_e_f), .LCD_RS(lcd_rs_f), .LCD_RW(lcd_rw_f), .LCD_data(lcd_bus_f)
   );

   typedef struct {
      logic       rd;
      logic       wr;
      logic [1:0] addr;
      logic [7:0] wdata;
      logic [7:0] resp;
      logic       exp_rw;
      logic       exp_rs;
      logic [7:0] exp_bus;
      logic       chk_rd;
      logic [7:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic       exp_rw;
      logic       exp_rs;
      logic [7:0] exp_bus;
      logic       chk_rd;
      logic [7:0] exp_rdata;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t       e;
      int         lat, ecnt, t1, t2, lowcnt;
      logic       s_rs, s_rw, eprev, done1;
      logic [7:0] s_bus;

      //            rd    wr    addr   wdata  resp   rw    rs    bus    chk   rdata
      vecs[0] = '{1'b0, 1'b1, 2'b10, 8'h41, 8'h00, 1'b0, 1'b1, 8'h41, 1'b1, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 2'b01, 8'h00, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 8'h80};
      vecs[2] = '{1'b1, 1'b0, 2'b11, 8'h00, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C};
      vecs[3] = '{1'b1, 1'b1, 2'b01, 8'h5A, 8'hC3, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h3C};
      vecs[4] = '{1'b0, 1'b1, 2'b11, 8'h0F, 8'hC3, 1'b0, 1'b1, 8'h0F, 1'b1, 8'h3C};
      vecs[5] = '{1'b1, 1'b0, 2'b00, 8'h00, 8'hC3, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00};

      reset = 1'b1; read = 1'b0; write = 1'b0; address = 2'b00; writedata = 8'h00;
      lcd_val = 8'h00;
      read_f = 1'b0; write_f = 1'b0; address_f = 2'b00; writedata_f = 8'h00;
      repeat (2) @(posedge clk);
      #1 write = 1'b1;
      @(negedge clk);
      check("rst_waitreq", {31'd0, waitrequest}, 1);
      check("rst_e", {31'd0, lcd_e}, 0);
      check("rst_rw", {31'd0, lcd_rw}, 1);
      check("rst_rs", {31'd0, lcd_rs}, 0);
      check("rst_readdata", {24'd0, readdata}, 8'h00);
      check("rst_bus", {24'd0, lcd_bus}, 8'hFF);
      @(posedge clk);
      #1 write = 1'b0; reset = 1'b0;
      repeat (3) @(posedge clk);

      for (int v = 0; v < 6; v++) begin
         @(posedge clk); #1;
         read = vecs[v].rd; write = vecs[v].wr; address = vecs[v].addr;
         writedata = vecs[v].wdata; lcd_val = vecs[v].resp;
         sb.push_back('{vecs[v].exp_rw, vecs[v].exp_rs, vecs[v].exp_bus,
                        vecs[v].chk_rd, vecs[v].exp_rdata});
         lat = -1; ecnt = 0; s_rs = 1'b0; s_rw = 1'b0; s_bus = 8'h00;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (lcd_e) begin
               ecnt++; s_rs = lcd_rs; s_rw = lcd_rw; s_bus = lcd_bus;
            end
            if (!waitrequest) begin
               lat = k;
               break;
            end
            @(posedge clk); #1;
         end
         e = sb.pop_front();
         check($sformatf("v%0d_latency", v), lat, 17);
         check($sformatf("v%0d_ehigh_cycles", v), ecnt, 12);
         check($sformatf("v%0d_rw", v), {31'd0, s_rw}, {31'd0, e.exp_rw});
         check($sformatf("v%0d_rs", v), {31'd0, s_rs}, {31'd0, e.exp_rs});
         check($sformatf("v%0d_bus", v), {24'd0, s_bus}, {24'd0, e.exp_bus});
         if (e.chk_rd) check($sformatf("v%0d_readdata", v), {24'd0, readdata}, {24'd0, e.exp_rdata});
         @(posedge clk); #1;
         read = 1'b0; write = 1'b0;
         repeat (30) @(posedge clk);
         @(negedge clk);
         check($sformatf("v%0d_idle_e", v), {31'd0, lcd_e}, 0);
         check($sformatf("v%0d_idle_rw", v), {31'd0, lcd_rw}, 1);
         check($sformatf("v%0d_idle_rs_hold", v), {31'd0, lcd_rs}, {31'd0, e.exp_rs});
         check($sformatf("v%0d_idle_bus", v), {24'd0, lcd_bus}, 8'hFF);
      end

      // Back-to-back writes: second request is held through the gap.
      @(posedge clk); #1;
      address = 2'b00; writedata = 8'h01; write = 1'b1;
      t1 = -1; t2 = -1; lowcnt = 0; eprev = 1'b0; done1 = 1'b0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (lcd_e && !eprev) begin
            if (t1 < 0) t1 = k;
            else if (t2 < 0) t2 = k;
         end
         eprev = lcd_e;
         if (done1 && t2 < 0 && !waitrequest) lowcnt++;
         if (!waitrequest && !done1) done1 = 1'b1;
         if (!waitrequest && t2 >= 0) break;
         @(posedge clk); #1;
         if (done1) writedata = 8'h02;
      end
      check("b2b_e_spacing", t2 - t1, 43);
      check("b2b_waitreq_low_in_gap", lowcnt, 0);
      check("b2b_second_data", {24'd0, lcd_bus}, 8'h02);
      @(posedge clk); #1;
      write = 1'b0;
      repeat (30) @(posedge clk);

      // Minimum timing on the fast instance with the request held throughout.
      @(posedge clk); #1;
      write_f = 1'b1; address_f = 2'b00; writedata_f = 8'h33;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         check($sformatf("fast_e_c%0d", k), {31'd0, lcd_e_f}, {31'd0, (k == 2 || k == 7)});
         check($sformatf("fast_waitreq_c%0d", k), {31'd0, waitrequest_f}, {31'd0, !(k == 4 || k == 9)});
         @(posedge clk); #1;
      end
      write_f = 1'b0;

      // Reset while E is high, request held: the cycle restarts from SETUP.
      @(posedge clk); #1;
      address = 2'b00; writedata = 8'h77; write = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         @(negedge clk);
         if (k == 8) check("mr_e_before_reset", {31'd0, lcd_e}, 1);
         if (k == 9) begin
            check("mr_e_after_reset", {31'd0, lcd_e}, 0);
            check("mr_rw_after_reset", {31'd0, lcd_rw}, 1);
            check("mr_bus_after_reset", {24'd0, lcd_bus}, 8'hFF);
            check("mr_readdata_after_reset", {24'd0, readdata}, 8'h00);
            check("mr_waitreq_idle", {31'd0, waitrequest}, 1);
         end
         if (k == 11) begin
            check("mr_restart_setup_e", {31'd0, lcd_e}, 0);
            check("mr_restart_setup_bus", {24'd0, lcd_bus}, 8'h77);
         end
         if (k == 12) check("mr_restart_e", {31'd0, lcd_e}, 1);
         if (k == 25) check("mr_waitreq_hold", {31'd0, waitrequest}, 1);
         if (k == 26) check("mr_waitreq_done", {31'd0, waitrequest}, 0);
         @(posedge clk); #1;
         if (k == 7) reset = 1'b1;
         if (k == 8) reset = 1'b0;
         if (k == 26) write = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_bus_sequencer.md
LCD_BUS_SEQUENCER -- requirements
Module: lcd_bus_sequencer

Parameters
REQ-001 T_SETUP, 2, clk cycles RS/RW/data stable before LCD_E rises (1..255).
REQ-002 T_EHIGH, 12, clk cycles LCD_E held high (1..255).
REQ-003 T_HOLD, 2, clk cycles RS/RW/data held after LCD_E falls (1..255).
REQ-004 T_GAP, 25, minimum idle clk cycles between bus cycles (0..255).

Interface
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 address  in  2  bit0 = LCD_RW value, bit1 = LCD_RS value.
REQ-008 read  in  1  Avalon read request, held until waitrequest low.
REQ-009 write  in  1  Avalon write request, held until waitrequest low.
REQ-010 writedata  in  8  byte to LCD.
REQ-011 readdata  out  8  byte captured from LCD.
REQ-012 waitrequest  out  1  Avalon stall.
REQ-013 LCD_E  out  1  HD44780 enable strobe.
REQ-014 LCD_RS  out  1  register select.
REQ-015 LCD_RW  out  1  1 = read, 0 = write.
REQ-016 LCD_data  inout  8  LCD data bus.

Function
REQ-017 States: IDLE, SETUP, EHIGH, HOLD, DONE, GAP; per-state down-counter, 8 bits.
REQ-018 IDLE and (read or write): latch address, writedata and direction; enter SETUP.
REQ-019 read and write together: write wins; cycle runs with RW=0 regardless of address[0].
REQ-020 Write cycle (address[0]=0 or write): latched RW=0; read with address[0]=1: RW=1; read with address[0]=0: RW=0 with no data driven.
REQ-021 SETUP lasts T_SETUP cycles, EHIGH T_EHIGH, HOLD T_HOLD, DONE 1, GAP T_GAP; T_GAP=0 goes DONE -> IDLE.
REQ-022 LCD_E = 1 only in EHIGH.
REQ-023 LCD_RS and LCD_RW = latched values SETUP..DONE; IDLE/GAP: LCD_RW=1, LCD_RS holds last value.
REQ-024 LCD_data = latched writedata SETUP..DONE when latched RW=0, write-type cycle; otherwise high-Z.
REQ-025 Read cycles: readdata <= LCD_data on last EHIGH cycle; readdata unchanged at all other times.
REQ-026 waitrequest = (read or write) and state != DONE (combinational).
REQ-027 Latency: request seen in IDLE at cycle 0 -> waitrequest low at cycle T_SETUP+T_EHIGH+T_HOLD+1 (17 with defaults).
REQ-028 Request arriving in SETUP..GAP: not accepted, waitrequest high; accepted on next IDLE cycle.
REQ-029 read/write dropped mid-cycle: cycle still completes with all timing; no new acceptance until IDLE.
REQ-030 Back-to-back requests: successive LCD_E rising edges at least T_SETUP+T_EHIGH+T_HOLD+1+T_GAP+1 cycles apart.

Reset
REQ-031 reset high (any state, mid-cycle included): next edge state=IDLE, counters=0, LCD_E=0, LCD_RW=1, LCD_RS=0, LCD_data high-Z, readdata=8'h00.
REQ-032 waitrequest during reset follows REQ-026 with state=IDLE.

Verification
REQ-033 Write address=2'b10, writedata=8'h41 at cycle 0 -> RS=1, RW=0, data=8'h41 from cycle 1; E high cycles 3..14; waitrequest low only at cycle 17; data Z from 18.
REQ-034 Read address=2'b01, LCD model drives 8'h80 during E -> readdata=8'h80 from cycle 15, waitrequest low at 17, LCD_data never driven by DUT.
REQ-035 Two back-to-back writes 8'h01, 8'h02 -> second E rise exactly 43 cycles after first (defaults); waitrequest high across GAP.
REQ-036 read and write both high, address=2'b01 -> RW=0, writedata driven, readdata unchanged.
REQ-037 reset asserted at cycle 8 of a write (E high) -> next edge E=0, RW=1, data Z, state IDLE; pending request then restarts from SETUP.
REQ-038 T_SETUP=T_EHIGH=T_HOLD=1, T_GAP=0 -> E high exactly 1 cycle, waitrequest low at cycle 4, next request accepted at cycle 5.
